// File: rtl/regfile_port_sched.sv
// regfile_port_sched
//   Scheduler and initialiser for a 2-write/1-read register-file RAM
//   (DATA_WDT x DEPTH, registered read data on port A).
//   After reset (or i_clear) every entry is written to INIT_VALUE, two
//   entries per cycle. In RUN, one read requester and two write requesters
//   are arbitrated onto the RAM ports. A read and a write never share a cycle.
//
// Ports
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_clear               RUN-only pulse that re-runs initialisation
//   o_init_busy           high while initialising
//   i_wr0_* / o_wr0_ready write requester 0 (valid/addr/data, ready)
//   i_wr1_* / o_wr1_ready write requester 1
//   i_rd_valid/addr       read request, o_rd_ready accepts it
//   o_rd_valid/o_rd_data  read response, one cycle after acceptance
//   o_ram_*               RAM address, write data and write enable
//   i_ram_rd_data         registered RAM read data (port A)
module regfile_port_sched #(
    parameter int unsigned         DATA_WDT   = 32,
    parameter int unsigned         ADDR_WDT   = 6,
    parameter int unsigned         DEPTH      = 46,
    parameter logic [DATA_WDT-1:0] INIT_VALUE = '0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_clear,
    output logic                o_init_busy,
    input  logic                i_wr0_valid,
    input  logic [ADDR_WDT-1:0] i_wr0_addr,
    input  logic [DATA_WDT-1:0] i_wr0_data,
    output logic                o_wr0_ready,
    input  logic                i_wr1_valid,
    input  logic [ADDR_WDT-1:0] i_wr1_addr,
    input  logic [DATA_WDT-1:0] i_wr1_data,
    output logic                o_wr1_ready,
    input  logic                i_rd_valid,
    input  logic [ADDR_WDT-1:0] i_rd_addr,
    output logic                o_rd_ready,
    output logic                o_rd_valid,
    output logic [DATA_WDT-1:0] o_rd_data,
    output logic [ADDR_WDT-1:0] o_ram_addr_a,
    output logic [ADDR_WDT-1:0] o_ram_addr_b,
    output logic                o_ram_wen,
    output logic [DATA_WDT-1:0] o_ram_wr_data_a,
    output logic [DATA_WDT-1:0] o_ram_wr_data_b,
    input  logic [DATA_WDT-1:0] i_ram_rd_data
);

    typedef enum logic {S_INIT, S_RUN} state_e;
    typedef enum logic {G_READ, G_WRITE} grant_e;

    // Two spare bits so idx+2 and DEPTH itself (up to 2^ADDR_WDT) fit.
    localparam int unsigned     CW      = ADDR_WDT + 2;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_WDT-1:0] LAST_C = ADDR_WDT'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_WDT-1:0] idx_q, idx_d;
    grant_e              last_grant_q, last_grant_d;
    logic                rd_pend_q, rd_pend_d;
    logic                rd_oor_q, rd_oor_d;

    logic [CW-1:0] idx_p1, idx_p2;
    logic          wr0_ok, wr1_ok, any_wr;

    function automatic logic in_range(input logic [ADDR_WDT-1:0] a);
        return CW'(a) < DEPTH_C;
    endfunction

    assign idx_p1 = CW'(idx_q) + CW'(1);
    assign idx_p2 = CW'(idx_q) + CW'(2);

    // Out-of-range writes are still accepted, they just never reach the RAM.
    assign wr0_ok = i_wr0_valid & in_range(i_wr0_addr);
    assign wr1_ok = i_wr1_valid & in_range(i_wr1_addr);
    assign any_wr = i_wr0_valid | i_wr1_valid;

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        last_grant_d    = last_grant_q;
        rd_pend_d       = 1'b0;
        rd_oor_d        = 1'b0;
        o_rd_ready      = 1'b0;
        o_wr0_ready     = 1'b0;
        o_wr1_ready     = 1'b0;
        o_ram_wen       = 1'b0;
        o_ram_addr_a    = '0;
        o_ram_addr_b    = '0;
        o_ram_wr_data_a = '0;
        o_ram_wr_data_b = '0;

        case (state_q)
            S_INIT: begin
                o_ram_wen       = 1'b1;
                o_ram_addr_a    = idx_q;
                // Odd DEPTH: the final pair rewrites the last entry twice.
                o_ram_addr_b    = (idx_p1 >= DEPTH_C) ? LAST_C : idx_p1[ADDR_WDT-1:0];
                o_ram_wr_data_a = INIT_VALUE;
                o_ram_wr_data_b = INIT_VALUE;
                if (idx_p2 >= DEPTH_C) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_p2[ADDR_WDT-1:0];
                end
            end

            default: begin
                if (i_clear) begin
                    state_d = S_INIT;
                    idx_d   = '0;
                end else if (i_rd_valid && (!any_wr || last_grant_q == G_WRITE)) begin
                    o_rd_ready   = 1'b1;
                    o_ram_addr_a = i_rd_addr;
                    rd_pend_d    = 1'b1;
                    rd_oor_d     = !in_range(i_rd_addr);
                    last_grant_d = G_READ;
                end else if (any_wr) begin
                    o_wr0_ready  = i_wr0_valid;
                    o_wr1_ready  = i_wr1_valid;
                    last_grant_d = G_WRITE;
                    o_ram_wen    = wr0_ok | wr1_ok;
                    if (wr0_ok && wr1_ok) begin
                        o_ram_addr_a    = i_wr0_addr;
                        o_ram_addr_b    = i_wr1_addr;
                        // Same address: both ports carry wr1 data so wr1 wins
                        // regardless of the RAM's port priority.
                        o_ram_wr_data_a = (i_wr0_addr == i_wr1_addr) ? i_wr1_data : i_wr0_data;
                        o_ram_wr_data_b = i_wr1_data;
                    end else if (wr0_ok) begin
                        o_ram_addr_a    = i_wr0_addr;
                        o_ram_addr_b    = i_wr0_addr;
                        o_ram_wr_data_a = i_wr0_data;
                        o_ram_wr_data_b = i_wr0_data;
                    end else if (wr1_ok) begin
                        o_ram_addr_a    = i_wr1_addr;
                        o_ram_addr_b    = i_wr1_addr;
                        o_ram_wr_data_a = i_wr1_data;
                        o_ram_wr_data_b = i_wr1_data;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= S_INIT;
            idx_q        <= '0;
            last_grant_q <= G_WRITE;
            rd_pend_q    <= 1'b0;
            rd_oor_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            rd_oor_q     <= rd_oor_d;
        end
    end

    assign o_init_busy = (state_q == S_INIT);
    assign o_rd_valid  = rd_pend_q;
    assign o_rd_data   = (rd_pend_q && !rd_oor_q) ? i_ram_rd_data : '0;

endmodule
